// File: rtl/sram_load_sequencer.sv
// Packs a host byte stream into 32-bit little-endian words and writes them
// through OpenRAM port 0, filling bank A then bank B, then pulses load_done.
module sram_load_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int WORDS_PER_BANK = 3444
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sram_csb_a,
  output logic              sram_web_a,
  output logic              sram_csb_b,
  output logic              sram_web_b,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic [3:0]        sram_wmask,
  output logic              busy,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_BANK - 1);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic              bank_b, bank_b_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [23:0]       word_p0, word_p0_nxt;
  logic [ADDR_W-1:0] sram_addr_nxt;
  logic [31:0]       sram_din_nxt;
  logic              wr_a_nxt, wr_b_nxt;

  always_comb begin
    state_nxt     = state;
    byte_idx_nxt  = byte_idx;
    bank_b_nxt    = bank_b;
    addr_nxt      = addr;
    word_p0_nxt   = word_p0;
    sram_addr_nxt = sram_addr;
    sram_din_nxt  = sram_din;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = PACK;
          addr_nxt     = '0;
          bank_b_nxt   = 1'b0;
          byte_idx_nxt = 2'd0;
        end
      end
      PACK: begin
        if (in_valid && in_ready) begin
          byte_idx_nxt = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_p0_nxt[7:0]   = in_data;
            2'd1: word_p0_nxt[15:8]  = in_data;
            2'd2: word_p0_nxt[23:16] = in_data;
            default: begin
              // Fourth byte goes straight into the write register
              sram_din_nxt  = {in_data, word_p0};
              sram_addr_nxt = addr;
              state_nxt     = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (addr != LAST_ADDR) begin
          addr_nxt  = addr + 1'b1;
          state_nxt = PACK;
        end else if (!bank_b) begin
          bank_b_nxt = 1'b1;
          addr_nxt   = '0;
          state_nxt  = PACK;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    wr_a_nxt = (state_nxt == WRITE) && !bank_b_nxt;
    wr_b_nxt = (state_nxt == WRITE) &&  bank_b_nxt;
  end

  // Registered outputs follow the next state so they line up with it
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      bank_b     <= 1'b0;
      addr       <= '0;
      in_ready   <= 1'b0;
      sram_csb_a <= 1'b1;
      sram_web_a <= 1'b1;
      sram_csb_b <= 1'b1;
      sram_web_b <= 1'b1;
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_wmask <= 4'h0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_idx   <= byte_idx_nxt;
      bank_b     <= bank_b_nxt;
      addr       <= addr_nxt;
      in_ready   <= (state_nxt == PACK);
      sram_csb_a <= !wr_a_nxt;
      sram_web_a <= !wr_a_nxt;
      sram_csb_b <= !wr_b_nxt;
      sram_web_b <= !wr_b_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_din   <= sram_din_nxt;
      sram_wmask <= (state_nxt == WRITE) ? 4'hF : 4'h0;
      busy       <= (state_nxt != IDLE);
      load_done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk_in) begin
    word_p0 <= word_p0_nxt;
  end

endmodule

// File: tb/tb_sram_load_sequencer.sv
// Directed bench: small-bank instance for packing/sequencing cases, default
// instance for the full-size two-bank load.
module tb_sram_load_sequencer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, csb_a, web_a, csb_b, web_b, busy, load_done;
  logic [11:0] addr;
  logic [31:0] din;
  logic [3:0]  wmask;

  logic        f_start = 1'b0, f_in_valid = 1'b0;
  logic [7:0]  f_in_data = 8'h00;
  logic        f_in_ready, f_csb_a, f_web_a, f_csb_b, f_web_b, f_busy, f_load_done;
  logic [11:0] f_addr;
  logic [31:0] f_din;
  logic [3:0]  f_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  sram_load_sequencer #(.ADDR_W(12), .WORDS_PER_BANK(4)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sram_csb_a(csb_a),
    .sram_web_a(web_a), .sram_csb_b(csb_b), .sram_web_b(web_b),
    .sram_addr(addr), .sram_din(din), .sram_wmask(wmask), .busy(busy),
    .load_done(load_done)
  );

  sram_load_sequencer dut_full (
    .clk_in(clk_in), .reset(reset), .start(f_start), .in_valid(f_in_valid),
    .in_data(f_in_data), .in_ready(f_in_ready), .sram_csb_a(f_csb_a),
    .sram_web_a(f_web_a), .sram_csb_b(f_csb_b), .sram_web_b(f_web_b),
    .sram_addr(f_addr), .sram_din(f_din), .sram_wmask(f_wmask), .busy(f_busy),
    .load_done(f_load_done)
  );

  typedef struct {
    logic        b;
    logic [11:0] addr;
    logic [31:0] din;
    logic [3:0]  wm;
    logic        web_ok;
    logic        ir;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0, last_wr_cyc = -1, ld_cyc = -1, ld_cnt = 0, both_low = 0;
  int  fa = 0, fb = 0, fboth = 0, fld = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!csb_a || !csb_b) begin
      wq.push_back('{b: !csb_b, addr: addr, din: din, wm: wmask,
                     web_ok: (!csb_b ? (!web_b && web_a) : (!web_a && web_b)),
                     ir: in_ready});
      last_wr_cyc = cyc;
    end
    if (!csb_a && !csb_b) both_low++;
    if (load_done) begin ld_cnt++; ld_cyc = cyc; end
    if (!f_csb_a) fa++;
    if (!f_csb_b) fb++;
    if (!f_csb_a && !f_csb_b) fboth++;
    if (f_load_done) fld++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    wq.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_write(input string tag, input int idx, input logic b,
                             input logic [11:0] a, input logic [31:0] d);
    if (idx >= wq.size()) begin
      chk({tag, "_present"}, 32'(wq.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_bank"}, 32'(wq[idx].b), 32'(b));
      chk({tag, "_addr"}, 32'(wq[idx].addr), 32'(a));
      chk({tag, "_din"}, wq[idx].din, d);
      chk({tag, "_wmask"}, 32'(wq[idx].wm), 32'hF);
      chk({tag, "_web"}, 32'(wq[idx].web_ok), 32'd1);
      chk({tag, "_ready_low"}, 32'(wq[idx].ir), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] e;
    logic        take;
    int          n;

    // 1: reset values, back-to-back word
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_csb", 32'({csb_a, csb_b, web_a, web_b}), 32'hF);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_wmask", 32'(wmask), 32'd0);
    chk("rst_busy_done", 32'({busy, load_done}), 32'd0);
    pulse_start();
    chk("t1_ready_pack", 32'(in_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    chk("t1_wr_ready", 32'(in_ready), 32'd0);
    chk("t1_wr_ctl", 32'({csb_a, web_a, csb_b, web_b}), 32'b0011);
    chk("t1_wr_addr", 32'(addr), 32'd0);
    chk("t1_wr_din", din, 32'h04030201);
    chk("t1_wr_wmask", 32'(wmask), 32'hF);
    tick();
    chk("t1_post_ready", 32'(in_ready), 32'd1);
    chk("t1_post_ctl", 32'({csb_a, web_a, csb_b, web_b, wmask}), 32'hF0);
    chk("t1_post_din_hold", din, 32'h04030201);
    chk("t1_nwrites", 32'(wq.size()), 32'd1);

    // 2: gapped bytes
    do_reset();
    pulse_start();
    send_byte(8'h01, 3); send_byte(8'h02, 3); send_byte(8'h03, 3); send_byte(8'h04, 3);
    repeat (10) tick();
    chk("t2_nwrites", 32'(wq.size()), 32'd1);
    check_write("t2", 0, 1'b0, 12'd0, 32'h04030201);

    // 3: two small banks
    do_reset();
    ld_cnt = 0;
    pulse_start();
    for (int i = 0; i < 32; i++) send_byte(8'(i + 1), 0);
    tick();
    chk("t3_done_pulse", 32'({load_done, busy}), 32'b11);
    tick();
    chk("t3_idle", 32'({load_done, busy, in_ready}), 32'd0);
    repeat (3) tick();
    chk("t3_nwrites", 32'(wq.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      e = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
      check_write($sformatf("t3_w%0d", j), j, (j >= 4), 12'(j % 4), e);
    end
    chk("t3_ld_count", 32'(ld_cnt), 32'd1);
    chk("t3_ld_latency", 32'(ld_cyc - last_wr_cyc), 32'd1);

    // 4: reset mid-word
    do_reset();
    pulse_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b1; tick();
    chk("t4_rst_ctl", 32'({csb_a, web_a, csb_b, web_b}), 32'hF);
    chk("t4_rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; tick();
    pulse_start();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    repeat (3) tick();
    chk("t4_nwrites", 32'(wq.size()), 32'd1);
    check_write("t4", 0, 1'b0, 12'd0, 32'h44332211);

    // 5: in_valid in IDLE, start mid-PACK
    do_reset();
    in_data = 8'hEE; in_valid = 1'b1;
    repeat (3) tick();
    chk("t5_idle_ready", 32'({in_ready, busy}), 32'd0);
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    pulse_start();
    chk("t5_still_pack", 32'({in_ready, busy}), 32'b11);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    repeat (3) tick();
    chk("t5_nwrites", 32'(wq.size()), 32'd1);
    check_write("t5", 0, 1'b0, 12'd0, 32'h04030201);
    chk("small_both_low", 32'(both_low), 32'd0);

    // 6: full-size load on the default instance
    f_in_valid = 1'b1; f_in_data = 8'h00;
    f_start = 1'b1; tick(); f_start = 1'b0;
    n = 0;
    while (fld == 0 && n < 40000) begin
      take = f_in_ready;
      tick();
      if (take) f_in_data = f_in_data + 8'd1;
      n++;
    end
    chk("t6_timeout", 32'(n < 40000), 32'd1);
    f_in_valid = 1'b0;
    repeat (5) tick();
    chk("t6_csb_a_count", 32'(fa), 32'd3444);
    chk("t6_csb_b_count", 32'(fb), 32'd3444);
    chk("t6_both_low", 32'(fboth), 32'd0);
    chk("t6_ld_count", 32'(fld), 32'd1);
    chk("t6_idle", 32'({f_busy, f_in_ready}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
